// File: rtl/ram_march_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_march_bist_if
// Purpose  : Single-port RAM access bus between the March BIST and the RAM.
// Revision : 1.0
// ============================================================================
interface ram_march_bist_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    address;
  logic             write_enable;
  logic             read_enable;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output address,
    output write_enable,
    output read_enable,
    output data_in,
    input  data_out
  );

  modport slave (
    input  address,
    input  write_enable,
    input  read_enable,
    input  data_in,
    output data_out
  );
endinterface
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : ram_march_bist
// Purpose  : March C- self-test initiator for a single-port synchronous RAM.
// Revision : 1.0
// ============================================================================
module ram_march_bist #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [AW-1:0]         fail_address,
  output logic [WIDTH-1:0]      fail_expected,
  output logic [WIDTH-1:0]      fail_actual,
  ram_march_bist_if.master      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0]    c_addr_first = '0;
  localparam logic [AW-1:0]    c_addr_last  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    c_addr_one   = AW'(1);
  localparam logic [WIDTH-1:0] c_p0         = '0;
  localparam logic [WIDTH-1:0] c_p1         = '1;
  localparam logic [2:0]       c_e0         = 3'd0;
  localparam logic [2:0]       c_e1         = 3'd1;
  localparam logic [2:0]       c_e2         = 3'd2;
  localparam logic [2:0]       c_e3         = 3'd3;
  localparam logic [2:0]       c_e4         = 3'd4;
  localparam logic [2:0]       c_e5         = 3'd5;

  state_t           r_state;
  logic [2:0]       r_elem;
  logic [AW-1:0]    r_address;
  logic             r_write_enable;
  logic             r_read_enable;
  logic [WIDTH-1:0] r_data_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [AW-1:0]    r_fail_address;
  logic [WIDTH-1:0] r_fail_expected;
  logic [WIDTH-1:0] r_fail_actual;
  logic             r_cmp_valid;
  logic [AW-1:0]    r_cmp_address;
  logic [WIDTH-1:0] r_cmp_expected;

  logic             w_descending;
  logic             w_terminal;
  logic             w_last_op;
  logic             w_next_read;
  logic [2:0]       w_next_elem;
  logic [AW-1:0]    w_next_address;
  logic [WIDTH-1:0] w_next_wdata;
  logic [WIDTH-1:0] w_read_pattern;
  logic             w_mismatch;

  // Next operation derived from the operation currently on the bus.
  always_comb begin
    w_descending   = (r_elem == c_e3) || (r_elem == c_e4);
    w_terminal     = w_descending ? (r_address == c_addr_first)
                                  : (r_address == c_addr_last);
    w_read_pattern = ((r_elem == c_e2) || (r_elem == c_e4)) ? c_p1 : c_p0;
    w_mismatch     = r_cmp_valid && (bus.data_out != r_cmp_expected);
    w_next_elem    = r_elem;
    w_next_address = r_address;
    w_next_read    = 1'b0;
    w_last_op      = 1'b0;
    if (r_elem == c_e0) begin
      if (w_terminal) begin
        w_next_elem    = c_e1;
        w_next_address = c_addr_first;
        w_next_read    = 1'b1;
      end else begin
        w_next_address = r_address + c_addr_one;
      end
    end else if (r_elem == c_e5) begin
      if (w_terminal) begin
        w_last_op = 1'b1;
      end else begin
        w_next_address = r_address + c_addr_one;
        w_next_read    = 1'b1;
      end
    end else if (r_read_enable) begin
      w_next_read = 1'b0;
    end else if (w_terminal) begin
      w_next_elem    = r_elem + 3'd1;
      w_next_address = ((w_next_elem == c_e3) || (w_next_elem == c_e4))
                       ? c_addr_last : c_addr_first;
      w_next_read    = 1'b1;
    end else begin
      w_next_address = w_descending ? (r_address - c_addr_one)
                                    : (r_address + c_addr_one);
      w_next_read    = 1'b1;
    end
    w_next_wdata = ((w_next_elem == c_e1) || (w_next_elem == c_e3)) ? c_p1 : c_p0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_elem          <= c_e0;
      r_address       <= '0;
      r_write_enable  <= 1'b0;
      r_read_enable   <= 1'b0;
      r_data_in       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_fail_address  <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
      r_cmp_valid     <= 1'b0;
      r_cmp_address   <= '0;
      r_cmp_expected  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_RUN;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_address  <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
            r_elem          <= c_e0;
            r_address       <= c_addr_first;
            r_write_enable  <= 1'b1;
            r_read_enable   <= 1'b0;
            r_data_in       <= c_p0;
            r_cmp_valid     <= 1'b0;
          end
        end
        S_RUN: begin
          r_cmp_valid    <= r_read_enable;
          r_cmp_address  <= r_address;
          r_cmp_expected <= w_read_pattern;
          if (w_mismatch) begin
            // The operation issued alongside this compare has completed; stop here.
            r_fail_address  <= r_cmp_address;
            r_fail_expected <= r_cmp_expected;
            r_fail_actual   <= bus.data_out;
            r_state         <= S_DONE;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_pass          <= 1'b0;
            r_write_enable  <= 1'b0;
            r_read_enable   <= 1'b0;
            r_data_in       <= '0;
            r_cmp_valid     <= 1'b0;
          end else if (w_last_op) begin
            r_state        <= S_DRAIN;
            r_write_enable <= 1'b0;
            r_read_enable  <= 1'b0;
            r_data_in      <= '0;
          end else begin
            r_elem         <= w_next_elem;
            r_address      <= w_next_address;
            r_read_enable  <= w_next_read;
            r_write_enable <= !w_next_read;
            r_data_in      <= w_next_read ? c_p0 : w_next_wdata;
          end
        end
        S_DRAIN: begin
          if (w_mismatch) begin
            r_fail_address  <= r_cmp_address;
            r_fail_expected <= r_cmp_expected;
            r_fail_actual   <= bus.data_out;
          end
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_pass      <= !w_mismatch;
          r_cmp_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign fail_address     = r_fail_address;
  assign fail_expected    = r_fail_expected;
  assign fail_actual      = r_fail_actual;
  assign bus.address      = r_address;
  assign bus.write_enable = r_write_enable;
  assign bus.read_enable  = r_read_enable;
  assign bus.data_in      = r_data_in;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_march_bist
// Purpose  : Self-checking bench for ram_march_bist with a faultable RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_march_bist;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, pass;
  logic [AW-1:0]    fail_address;
  logic [WIDTH-1:0] fail_expected, fail_actual;

  ram_march_bist_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_march_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_address  (fail_address),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  // kind: 0 none, 1 read bit stuck at val at a_addr, 2 writes to a_addr also land at b_addr
  typedef struct {
    logic [1:0]    kind;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [2:0]    bitn;
    logic          val;
  } fault_t;

  typedef struct packed {
    logic             we;
    logic             re;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } op_t;

  typedef struct {
    fault_t           f;
    logic             poke;
    logic             exp_pass;
    int               exp_done;
    logic [AW-1:0]    exp_fa;
    logic [WIDTH-1:0] exp_fe;
    logic [WIDTH-1:0] exp_fact;
    int               exp_wr;
    int               exp_rd;
  } vec_t;

  fault_t           flt;
  logic [WIDTH-1:0] mem [DEPTH];
  op_t              march_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic fault_t mk_fault(logic [1:0] k, logic [AW-1:0] a, logic [AW-1:0] b,
                                      logic [2:0] bn, logic v);
    fault_t f;
    f.kind = k; f.a_addr = a; f.b_addr = b; f.bitn = bn; f.val = v;
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] fault_read(logic [WIDTH-1:0] stored, logic [AW-1:0] a);
    logic [WIDTH-1:0] r;
    r = stored;
    if (flt.kind == 2'd1 && a == flt.a_addr) r[flt.bitn] = flt.val;
    return r;
  endfunction

  // Synchronous single-port RAM with optional planted fault.
  always @(posedge clock) begin
    if (bus.write_enable) begin
      mem[bus.address] <= bus.data_in;
      if (flt.kind == 2'd2 && bus.address == flt.a_addr) mem[flt.b_addr] <= bus.data_in;
    end
    if (bus.read_enable) bus.data_out <= fault_read(mem[bus.address], bus.address);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // March C- written straight from its element list.
  task automatic build_march();
    logic [WIDTH-1:0] wp;
    int a;
    march_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a  = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
        wp = (e == 1 || e == 3) ? '1 : '0;
        if (e != 0) march_q.push_back('{1'b0, 1'b1, AW'(a), {WIDTH{1'b0}}});
        if (e != 5) march_q.push_back('{1'b1, 1'b0, AW'(a), wp});
      end
    end
  endtask

  // Replays the sequence on ideal and faulty memories; first read divergence fails.
  task automatic predict(output int n_ops, output int done_cyc, output logic ep,
                         output logic [AW-1:0] fa, output logic [WIDTH-1:0] fe,
                         output logic [WIDTH-1:0] fact);
    logic [WIDTH-1:0] ideal [DEPTH];
    logic [WIDTH-1:0] realm [DEPTH];
    logic [WIDTH-1:0] v;
    ep = 1'b1; fa = '0; fe = '0; fact = '0;
    n_ops = march_q.size(); done_cyc = n_ops + 2;
    for (int k = 0; k < march_q.size(); k++) begin
      if (march_q[k].we) begin
        ideal[march_q[k].addr] = march_q[k].data;
        realm[march_q[k].addr] = march_q[k].data;
        if (flt.kind == 2'd2 && march_q[k].addr == flt.a_addr) realm[flt.b_addr] = march_q[k].data;
      end else begin
        v = fault_read(realm[march_q[k].addr], march_q[k].addr);
        if (v !== ideal[march_q[k].addr]) begin
          ep = 1'b0; fa = march_q[k].addr; fe = ideal[march_q[k].addr]; fact = v;
          n_ops = (k + 2 < march_q.size()) ? k + 2 : march_q.size();
          done_cyc = k + 3;
          break;
        end
      end
    end
  endtask

  task automatic run_test(input string tag, input logic poke, output int done_cyc,
                          output logic p, output logic [AW-1:0] fa,
                          output logic [WIDTH-1:0] fe, output logic [WIDTH-1:0] fact,
                          output int wr, output int rd);
    int n_exp, exp_done, cyc, bad_ops, both, busy_bad, hold_bad;
    logic ep;
    logic [AW-1:0] efa;
    logic [WIDTH-1:0] efe, efact;
    op_t got;
    predict(n_exp, exp_done, ep, efa, efe, efact);
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    check({tag, "_start_busy"}, int'(busy), 1);
    check({tag, "_start_clears"}, int'({done, pass, fail_address, fail_expected, fail_actual}), 0);
    cyc = 1; done_cyc = 0; bad_ops = 0; both = 0; busy_bad = 0; wr = 0; rd = 0;
    while (cyc < 400) begin
      if (done) begin done_cyc = cyc; break; end
      got = '{bus.write_enable, bus.read_enable, bus.address, bus.data_in};
      if (got.we && got.re) both++;
      if (!busy) busy_bad++;
      wr += int'(got.we); rd += int'(got.re);
      if (cyc <= n_exp) begin
        if (got !== march_q[cyc-1]) bad_ops++;
      end else if (got.we || got.re || got.data != '0) begin
        bad_ops++;
      end
      start = (poke && cyc == 20) ? 1'b1 : 1'b0;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_op_trace"}, bad_ops, 0);
    check({tag, "_both_enables"}, both, 0);
    check({tag, "_busy_during"}, busy_bad, 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_model_pass"}, int'(pass), int'(ep));
    check({tag, "_model_fail_info"}, int'({fail_address, fail_expected, fail_actual}),
          int'({efa, efe, efact}));
    p = pass; fa = fail_address; fe = fail_expected; fact = fail_actual;
    hold_bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.write_enable || bus.read_enable || !done || busy) hold_bad++;
    end
    check({tag, "_quiet_after_done"}, hold_bad, 0);
  endtask

  initial begin
    vec_t             tbl[5];
    int               dc, wr, rd;
    logic             p;
    logic [AW-1:0]    fa;
    logic [WIDTH-1:0] fe, fact;
    string            tag;

    tbl[0] = '{mk_fault(2'd0, 4'd0, 4'd0, 3'd0, 1'b0), 1'b0, 1'b1, 162, 4'd0, 8'h00, 8'h00, 80, 80};
    tbl[1] = '{mk_fault(2'd1, 4'd5, 4'd0, 3'd3, 1'b0), 1'b0, 1'b0, 61,  4'd5, 8'hFF, 8'hF7, 38, 22};
    tbl[2] = '{mk_fault(2'd2, 4'd8, 4'd9, 3'd0, 1'b0), 1'b0, 1'b0, 37,  4'd9, 8'h00, 8'hFF, 26, 10};
    tbl[3] = '{mk_fault(2'd2, 4'd9, 4'd8, 3'd0, 1'b0), 1'b0, 1'b0, 97,  4'd8, 8'h00, 8'hFF, 56, 40};
    tbl[4] = '{mk_fault(2'd0, 4'd0, 4'd0, 3'd0, 1'b0), 1'b1, 1'b1, 162, 4'd0, 8'h00, 8'h00, 80, 80};

    flt = mk_fault(2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
    build_march();
    repeat (3) @(negedge clock);
    check("reset_status", int'({busy, done, pass}), 0);
    check("reset_bus", int'({bus.write_enable, bus.read_enable, bus.address, bus.data_in}), 0);
    check("reset_fail_info", int'({fail_address, fail_expected, fail_actual}), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      flt = tbl[i].f;
      tag = $sformatf("vec%0d", i);
      run_test(tag, tbl[i].poke, dc, p, fa, fe, fact, wr, rd);
      check({tag, "_tbl_done_cycle"}, dc, tbl[i].exp_done);
      check({tag, "_tbl_pass"}, int'(p), int'(tbl[i].exp_pass));
      check({tag, "_tbl_fail_address"}, int'(fa), int'(tbl[i].exp_fa));
      check({tag, "_tbl_fail_expected"}, int'(fe), int'(tbl[i].exp_fe));
      check({tag, "_tbl_fail_actual"}, int'(fact), int'(tbl[i].exp_fact));
      check({tag, "_tbl_writes"}, wr, tbl[i].exp_wr);
      check({tag, "_tbl_reads"}, rd, tbl[i].exp_rd);
    end

    // Asynchronous reset in the middle of a run.
    flt = mk_fault(2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (39) @(negedge clock);
    check("midreset_busy_before", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("midreset_status", int'({busy, done, pass}), 0);
    check("midreset_bus", int'({bus.write_enable, bus.read_enable, bus.address, bus.data_in}), 0);
    check("midreset_fail_info", int'({fail_address, fail_expected, fail_actual}), 0);
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_after_reset", int'({busy, done, bus.write_enable, bus.read_enable}), 0);
    run_test("after_reset", 1'b0, dc, p, fa, fe, fact, wr, rd);
    check("after_reset_done_cycle", dc, 162);
    check("after_reset_pass", int'(p), 1);

    // Random single faults checked against the reference model.
    for (int r = 0; r < 6; r++) begin
      flt = mk_fault(2'($urandom_range(1, 2)), AW'($urandom_range(0, DEPTH - 1)), 4'd0,
                     3'($urandom_range(0, WIDTH - 1)), 1'($urandom_range(0, 1)));
      flt.b_addr = flt.a_addr + AW'($urandom_range(1, DEPTH - 1));
      run_test($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), dc, p, fa, fe, fact, wr, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
